// File: rtl/clock_pkg.sv
// Shared clock-chain definitions: digit limits, BCD digit type, debounce states.
// Latency: n/a (types and constants only).
// Backpressure: n/a; reused unchanged by the seconds, minute and hour stages.
package clock_pkg;

    // Highest value reached by the seconds and minutes counters before wrapping.
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // One decimal digit as shown on a seven-segment position.
    typedef logic [3:0] bcd_digit_t;

    // Debounce states. REL and WAIT_PRESS accept level 1 (released);
    // PRESSED and WAIT_REL accept level 0 (pressed, active-low key).
    typedef enum logic [1:0] {
        REL        = 2'd0,
        WAIT_PRESS = 2'd1,
        PRESSED    = 2'd2,
        WAIT_REL   = 2'd3
    } deb_state_t;

endpackage

// File: rtl/nut_debounce.sv
// Push-button conditioner: 2-flop synchroniser + debounce FSM, one-cycle clr_pulse per accepted press.
// Latency: raw falling edge to clr_pulse is 2 + DEB_CYCLES cycles; clr_pulse is combinational from state.
// Backpressure: none; holding the key gives one pulse, a new pulse needs a debounced release first.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn        raw active-low key, asynchronous and bouncing
//   clr_pulse  one-cycle pulse when a press has been stable for DEB_CYCLES cycles
module nut_debounce
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic clr_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    deb_state_t    state;
    deb_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Synchroniser resets to 1 so an idle (released) key produces no event
    // when reset is removed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_pulse  = 1'b0;
        case (state)
            REL: begin
                if (!sync_b) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                // Any return to the released level restarts the qualification.
                if (sync_b) begin
                    state_next = REL;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    clr_pulse  = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (sync_b) begin
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end
            end
            WAIT_REL: begin
                if (!sync_b) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = REL;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = REL;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/counter_giay.sv
// Seconds stage: 1 Hz prescaler, 00-59 BCD seconds, wrap pulse for the minute stage, debounced clear key.
// Latency: tick_1hz/inc_minute registered, high the cycle after the terminal count together with the new BCD value.
// Backpressure: none; run_en=0 freezes prescaler and seconds, clear works even while paused.
//
// Ports:
//   clk          system clock (only clock)
//   rst          asynchronous active-low reset
//   run_en       1 = run, 0 = pause (already synchronous)
//   btn_clr_sec  raw active-low clear-seconds key
//   bcd_HEX0     seconds units digit 0-9
//   bcd_HEX1     seconds tens digit 0-5
//   tick_1hz     one-cycle pulse per elapsed second
//   inc_minute   one-cycle pulse when seconds wrap 59 -> 00
module counter_giay
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       btn_clr_sec,
    output bcd_digit_t bcd_HEX0,
    output bcd_digit_t bcd_HEX1,
    output logic       tick_1hz,
    output logic       inc_minute
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX);

    logic [PW-1:0] presc;
    logic [5:0]    sec;
    logic          clr_pulse;
    logic          term;

    nut_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_nut_clr (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_clr_sec),
        .clr_pulse (clr_pulse)
    );

    // Terminal count only matters while running; a paused prescaler sitting
    // at its last value must not keep advancing the seconds.
    assign term = run_en && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            sec        <= '0;
            bcd_HEX0   <= '0;
            bcd_HEX1   <= '0;
            tick_1hz   <= 1'b0;
            inc_minute <= 1'b0;
        end else if (clr_pulse) begin
            // Clear beats a coincident terminal count: that second is dropped
            // and no tick or wrap reaches the minute stage.
            presc      <= '0;
            sec        <= '0;
            bcd_HEX0   <= '0;
            bcd_HEX1   <= '0;
            tick_1hz   <= 1'b0;
            inc_minute <= 1'b0;
        end else if (term) begin
            presc    <= '0;
            tick_1hz <= 1'b1;
            if (sec == SEC_LAST) begin
                sec        <= '0;
                bcd_HEX0   <= '0;
                bcd_HEX1   <= '0;
                inc_minute <= 1'b1;
            end else begin
                sec        <= sec + 6'd1;
                inc_minute <= 1'b0;
                // Digits step alongside sec instead of being divided out of it.
                if (bcd_HEX0 == 4'd9) begin
                    bcd_HEX0 <= '0;
                    bcd_HEX1 <= bcd_HEX1 + 4'd1;
                end else begin
                    bcd_HEX0 <= bcd_HEX0 + 4'd1;
                end
            end
        end else begin
            tick_1hz   <= 1'b0;
            inc_minute <= 1'b0;
            if (run_en) begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_giay.sv
module tb_counter_giay;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       run_en = 1'b0;
    logic       btn    = 1'b1;
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic       tick;
    logic       inc;

    counter_giay #(
        .CLK_HZ     (CLK_HZ),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .btn_clr_sec (btn),
        .bcd_HEX0    (hex0),
        .bcd_HEX1    (hex1),
        .tick_1hz    (tick),
        .inc_minute  (inc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: seconds as a plain integer, elapsed cycles within the
    // current second, the button seen through a two-cycle delay, and a run
    // length of cycles the delayed button disagrees with the accepted level.
    // A level is accepted once it has disagreed for DEB+1 consecutive cycles.
    int m_sec   = 0;
    int m_phase = 0;
    int m_run   = 0;
    bit m_tick  = 0;
    bit m_inc   = 0;
    bit m_d1    = 1;
    bit m_d2    = 1;
    bit m_acc   = 1;

    always @(posedge clk or negedge rst) begin : model_p
        bit clr;
        if (!rst) begin
            m_sec = 0; m_phase = 0; m_run = 0;
            m_tick = 0; m_inc = 0;
            m_d1 = 1; m_d2 = 1; m_acc = 1;
        end else begin
            clr = 0;
            if (m_d2 != m_acc) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_acc = m_d2;
                    m_run = 0;
                    clr   = (m_acc == 0);
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = btn;
            m_tick = 0;
            m_inc  = 0;
            if (clr) begin
                m_sec   = 0;
                m_phase = 0;
            end else if (run_en) begin
                m_phase++;
                if (m_phase == CLK_HZ) begin
                    m_phase = 0;
                    m_tick  = 1;
                    m_inc   = (m_sec == 59);
                    m_sec   = (m_sec + 1) % 60;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("hex0", hex0, m_sec % 10);
            check("hex1", hex1, m_sec / 10);
            check("tick", tick, m_tick);
            check("inc",  inc,  m_inc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        run_en = 1'b0;
        btn    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_hex(input string name, input int t, input int o, input int maxc);
        int n;
        n = 0;
        while (!(hex1 == 4'(t) && hex0 == 4'(o)) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, (hex1 == 4'(t) && hex0 == 4'(o)) ? 1 : 0, 1);
    endtask

    // Counts negedges until tick is seen; returns maxc+1 if it never comes.
    task automatic cycles_to_tick(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n <= maxc);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 2000000");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nt, ni, last, bad_gap, inc_at, n, tseen, iseen, hold_ok;

        // Reset values, asynchronously before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_hex0", hex0, 0);
        check("rst_hex1", hex1, 0);
        check("rst_tick", tick, 0);
        check("rst_inc",  inc,  0);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // 100 running cycles: ten ticks ten cycles apart, ending on 1:0.
        do_reset();
        run_en = 1'b1;
        nt = 0; ni = 0; last = -1; bad_gap = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (tick) begin
                if (nt == 0) check("first_tick_cycle", c, 10);
                if (last >= 0 && c - last != 10) bad_gap++;
                last = c;
                nt++;
            end
            if (inc) ni++;
        end
        check("s1_ticks", nt, 10);
        check("s1_gaps", bad_gap, 0);
        check("s1_inc", ni, 0);
        check("s1_hex1", hex1, 1);
        check("s1_hex0", hex0, 0);

        // 600 cycles from 00: exactly one wrap, showing 0:0 with a tick.
        do_reset();
        run_en = 1'b1;
        ni = 0; inc_at = -1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (inc) begin
                ni++;
                inc_at = c;
                check("s2_inc_tick", tick, 1);
                check("s2_inc_hex", {hex1, hex0}, 0);
            end
        end
        check("s2_inc_count", ni, 1);
        check("s2_inc_cycle", inc_at, 600);

        // Pause at 37 with 3 cycles of the second already spent.
        do_reset();
        run_en = 1'b1;
        wait_hex("s3_reach_37", 3, 7, 500);
        repeat (3) @(negedge clk);
        run_en = 1'b0;
        tseen = 0;
        repeat (55) begin
            @(negedge clk);
            if (tick) tseen++;
        end
        check("s3_pause_ticks", tseen, 0);
        check("s3_hold_hex1", hex1, 3);
        check("s3_hold_hex0", hex0, 7);
        run_en = 1'b1;
        cycles_to_tick(20, n);
        check("s3_resume_gap", n, 7);
        check("s3_after_hex0", hex0, 8);

        // Bounce then hold: no clear during bounce, one clear, none while held.
        do_reset();
        run_en = 1'b1;
        repeat (50) @(negedge clk);
        run_en = 1'b0;
        hold_ok = 1;
        for (int i = 0; i < 20; i++) begin
            btn = (i % 4 < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (hex0 != 4'd5 || hex1 != 4'd0) hold_ok = 0;
        end
        check("s4_bounce_no_clear", hold_ok, 1);
        btn = 1'b0;
        n = 0;
        while (hex0 != 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s4_clear_latency", n, 7);
        run_en = 1'b1;
        repeat (15) @(negedge clk);
        check("s4_held_hex1", hex1, 0);
        check("s4_held_hex0", hex0, 1);
        btn = 1'b1;
        repeat (10) @(negedge clk);

        // Clear lands on the terminal count at 59.
        do_reset();
        run_en = 1'b1;
        wait_hex("s5_reach_59", 5, 9, 700);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        tseen = 0; iseen = 0;
        repeat (7) begin
            @(negedge clk);
            if (tick) tseen++;
            if (inc) iseen++;
        end
        check("s5_hex", {hex1, hex0}, 0);
        check("s5_no_tick", tseen, 0);
        check("s5_no_inc", iseen, 0);
        cycles_to_tick(20, n);
        check("s5_next_tick", n, 10);
        btn = 1'b1;
        repeat (10) @(negedge clk);

        // Reset at sec=42, prescaler=7, debouncer in WAIT_PRESS.
        do_reset();
        run_en = 1'b1;
        repeat (424) @(negedge clk);
        btn = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_hex1_pre", hex1, 4);
        check("s6_hex0_pre", hex0, 2);
        #1 rst = 1'b0;
        #1;
        check("s6_rst_hex", {hex1, hex0}, 0);
        check("s6_rst_tick", tick, 0);
        check("s6_rst_inc", inc, 0);
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b1;
        cycles_to_tick(20, n);
        check("s6_first_tick", n, 10);

        // Random run/pause, bouncing and held key, occasional reset.
        do_reset();
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            run_en = ($urandom_range(0, 9) != 0);
            btn    = $urandom_range(0, 1);
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        btn = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
